// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, transmitter state type and frame helpers
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] DB_5 = 2'd0;
  localparam logic [1:0] DB_6 = 2'd1;
  localparam logic [1:0] DB_7 = 2'd2;
  localparam logic [1:0] DB_8 = 2'd3;

  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;

  // Selects the active character bits so unused upper bits never reach parity.
  function automatic logic [DATA_W-1:0] data_mask(input logic [1:0] bits_code);
    case (bits_code)
      DB_5:    return 8'h1F;
      DB_6:    return 8'h3F;
      DB_7:    return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // Index of the final data bit: character length minus one (4..7).
  function automatic logic [2:0] last_idx(input logic [1:0] bits_code);
    return {1'b1, bits_code};
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// rtl/uart_tx_frame_if.sv - character handshake between a producer and the UART transmitter
interface uart_tx_frame_if #(
  parameter int MAX_BITS = 8
);
  logic                tx_valid;
  logic [MAX_BITS-1:0] tx_data;
  logic                tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period down-counter giving one tick per baud interval
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  // Counting down to zero and reloading the divider never overflows, even at all-ones.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt <= '0;
    end else if (i_load || o_tick) begin
      r_cnt <= i_div;
    end else if (i_en) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter with runtime character length, parity and stop bits
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int MAX_BITS = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [DIV_W-1:0] cfg_baud_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_parity_en,
  input  logic             cfg_parity_odd,
  input  logic             cfg_stop2,
  uart_tx_frame_if.slave   tx_if,
  output logic             tx_serial,
  output logic             tx_busy,
  output logic             tx_done
);

  tx_state_t           r_state;
  logic [MAX_BITS-1:0] r_data;
  logic [1:0]          r_bits;
  logic                r_par_en;
  logic                r_par_bit;
  logic                r_stop2;
  logic                r_stop_second;
  logic [2:0]          r_idx;
  logic [DIV_W-1:0]    r_div;
  logic                r_serial;
  logic                r_done;

  logic                w_idle;
  logic                w_tick;
  logic [2:0]          w_idx_nxt;
  logic                w_par_in;

  assign w_idle         = (r_state == IDLE);
  assign w_idx_nxt      = r_idx + 3'd1;
  assign w_par_in       = (^(tx_if.tx_data & data_mask(cfg_data_bits))) ^ cfg_parity_odd;
  assign tx_if.tx_ready = w_idle;
  assign tx_busy        = !w_idle;
  assign tx_serial      = r_serial;
  assign tx_done        = r_done;

  // While idle the counter tracks the live divider so acceptance starts a full bit period.
  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .i_load (w_idle),
    .i_en   (!w_idle),
    .i_div  (w_idle ? cfg_baud_div : r_div),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state       <= IDLE;
      r_data        <= '0;
      r_bits        <= DB_5;
      r_par_en      <= 1'b0;
      r_par_bit     <= 1'b0;
      r_stop2       <= STOP_1;
      r_stop_second <= 1'b0;
      r_idx         <= 3'd0;
      r_div         <= '0;
      r_serial      <= 1'b1;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_serial <= 1'b1;
          if (tx_if.tx_valid) begin
            // Parity is resolved here so later cfg changes cannot alter the frame.
            r_data        <= tx_if.tx_data;
            r_bits        <= cfg_data_bits;
            r_par_en      <= cfg_parity_en;
            r_par_bit     <= w_par_in;
            r_stop2       <= cfg_stop2;
            r_div         <= cfg_baud_div;
            r_idx         <= 3'd0;
            r_stop_second <= 1'b0;
            r_serial      <= 1'b0;
            r_state       <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_idx    <= 3'd0;
            r_serial <= r_data[0];
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_idx == last_idx(r_bits)) begin
              if (r_par_en) begin
                r_serial <= r_par_bit;
                r_state  <= PARITY;
              end else begin
                r_serial <= 1'b1;
                r_state  <= STOP;
              end
            end else begin
              r_idx    <= w_idx_nxt;
              r_serial <= r_data[w_idx_nxt];
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_serial <= 1'b1;
            r_state  <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            if ((r_stop2 == STOP_2) && !r_stop_second) begin
              r_stop_second <= 1'b1;
            end else begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_serial <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int DIV_W = 4;

  typedef struct {
    logic [DIV_W-1:0] div;
    logic [7:0]       data;
    logic [1:0]       bits;
    logic             par_en;
    logic             par_odd;
    logic             stop2;
    int               exp_f;
    logic             exp_par;
  } vec_t;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic [DIV_W-1:0] cfg_baud_div = '0;
  logic [1:0]       cfg_data_bits = 2'd3;
  logic             cfg_parity_en = 1'b0;
  logic             cfg_parity_odd = 1'b0;
  logic             cfg_stop2 = 1'b0;
  logic             tx_serial;
  logic             tx_busy;
  logic             tx_done;

  uart_tx_frame_if #(.MAX_BITS(8)) tx_if ();

  int   n_checks = 0;
  int   n_pass = 0;
  logic exp_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  uart_tx_frame #(.DIV_W(DIV_W), .MAX_BITS(8)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .cfg_baud_div   (cfg_baud_div),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .tx_if          (tx_if),
    .tx_serial      (tx_serial),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic apply(input vec_t v);
    cfg_baud_div   = v.div;
    cfg_data_bits  = v.bits;
    cfg_parity_en  = v.par_en;
    cfg_parity_odd = v.par_odd;
    cfg_stop2      = v.stop2;
    tx_if.tx_data  = v.data;
  endtask

  // Reference line model: one queue entry per clock cycle of the frame.
  task automatic push_frame(input vec_t v);
    int   d;
    int   n;
    logic p;
    d = int'(v.div) + 1;
    n = int'(v.bits) + 5;
    p = v.par_odd;
    for (int i = 0; i < n; i++) p = p ^ v.data[i];
    repeat (d) exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) repeat (d) exp_q.push_back(v.data[i]);
    if (v.par_en) repeat (d) exp_q.push_back(p);
    repeat (d * (v.stop2 ? 2 : 1)) exp_q.push_back(1'b1);
  endtask

  task automatic do_frame(input vec_t v, input bit has_nxt, input vec_t nxt, input bit poke);
    int   d;
    int   n;
    int   par_k;
    int   bad;
    logic exp_bit;
    d     = int'(v.div) + 1;
    n     = int'(v.bits) + 5;
    par_k = (1 + n) * d + 1;
    bad   = 0;
    check("ready_before_accept", tx_if.tx_ready, 1'b1);
    apply(v);
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    push_frame(v);
    for (int k = 1; k <= v.exp_f; k++) begin
      @(negedge clk);
      exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      check("line", tx_serial, exp_bit);
      if (v.par_en && k == par_k) check("parity_bit", tx_serial, v.exp_par);
      if (tx_busy !== 1'b1 || tx_done !== 1'b0 || tx_if.tx_ready !== 1'b0) bad++;
      if (k == 1 && !has_nxt) tx_if.tx_valid = 1'b0;
      if (k == 2) begin
        if (has_nxt) apply(nxt);
        else begin
          cfg_baud_div   = DIV_W'($urandom);
          cfg_data_bits  = 2'($urandom);
          cfg_parity_en  = 1'($urandom);
          cfg_parity_odd = 1'($urandom);
          cfg_stop2      = 1'($urandom);
          tx_if.tx_data  = 8'($urandom);
        end
      end
      if (poke && k == v.exp_f / 2) begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = ~v.data;
      end
      if (poke && k == v.exp_f / 2 + 1) begin
        check("ready_while_busy", tx_if.tx_ready, 1'b0);
        tx_if.tx_valid = 1'b0;
      end
    end
    check("busy_flags_in_frame", bad, 0);
    @(negedge clk);
    check("done_pulse", tx_done, 1'b1);
    check("ready_at_done", tx_if.tx_ready, 1'b1);
    check("idle_gap_line", tx_serial, 1'b1);
    exp_q.delete();
  endtask

  initial begin
    vec_t rv;
    int   bad;
    logic exp_bit;
    vecs[0] = '{4'd3,  8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 40,  1'b0};
    vecs[1] = '{4'd0,  8'hC3, 2'd2, 1'b1, 1'b0, 1'b0, 10,  1'b1};
    vecs[2] = '{4'd1,  8'h1F, 2'd0, 1'b1, 1'b1, 1'b1, 18,  1'b0};
    vecs[3] = '{4'd2,  8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 30,  1'b0};
    vecs[4] = '{4'd1,  8'h3C, 2'd1, 1'b1, 1'b1, 1'b1, 20,  1'b1};
    vecs[5] = '{4'd2,  8'h96, 2'd3, 1'b1, 1'b0, 1'b0, 33,  1'b0};
    vecs[6] = '{4'd15, 8'h01, 2'd3, 1'b1, 1'b0, 1'b0, 176, 1'b1};
    vecs[7] = '{4'd1,  8'h6A, 2'd3, 1'b1, 1'b1, 1'b1, 24,  1'b1};
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;

    repeat (2) @(negedge clk);
    check("reset_serial", tx_serial, 1'b1);
    check("reset_ready", tx_if.tx_ready, 1'b1);
    check("reset_busy", tx_busy, 1'b0);
    check("reset_done", tx_done, 1'b0);
    arst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      if (i == 4) continue;
      do_frame(vecs[i], (i == 3), vecs[(i == 3) ? 4 : i], (i == 5));
      if (i == 3) do_frame(vecs[4], 1'b0, vecs[4], 1'b0);
    end

    // Reset in the middle of the data bits of an all-zero character.
    rv = '{4'd3, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0, 40, 1'b0};
    apply(rv);
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    push_frame(rv);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      check("pre_reset_line", tx_serial, exp_bit);
      if (k == 1) tx_if.tx_valid = 1'b0;
    end
    exp_q.delete();
    #2 arst_n = 1'b0;
    #1;
    check("async_reset_serial", tx_serial, 1'b1);
    check("async_reset_ready", tx_if.tx_ready, 1'b1);
    check("async_reset_busy", tx_busy, 1'b0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_serial !== 1'b1) bad++;
    end
    arst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_serial !== 1'b1) bad++;
    end
    check("no_done_after_abort", bad, 0);
    do_frame(vecs[7], 1'b0, vecs[7], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
